// File: rtl/prom_rd.sv
// Program ROM read port: 16 x 8 image loaded through a byte-stream port, read onto the W bus by one-hot select.
// Optional macro PROM_ONEHOT_CHECK_EN zeroes reads on a non-one-hot select and flags them on sel_err.
module prom_rd (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] sel,
    input  logic        ce,
    output logic [7:0]  wout,
    input  logic        prog_mode,
    input  logic        prog_valid,
    input  logic [7:0]  prog_data,
    output logic        prog_ready,
    output logic        prog_done,
    output logic        sel_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_ptr;
    logic [7:0]  r_mem [16];
    logic [7:0]  r_rd_q;
    logic        r_oe_q;
    logic        r_done;

    logic [3:0]  w_idx;
    logic [7:0]  w_rd_data;

    // Scanning from the top down leaves the lowest set bit as the winner.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (sel[i]) w_idx = 4'(i);
        end
    end

`ifdef PROM_ONEHOT_CHECK_EN
    logic w_err;
    logic r_sel_err;

    assign w_err     = (sel == 16'h0000) || ((sel & (sel - 16'd1)) != 16'h0000);
    assign w_rd_data = w_err ? 8'h00 : r_mem[w_idx];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sel_err <= 1'b0;
        end else if (r_state != LOAD && prog_mode) begin
            r_sel_err <= 1'b0;
        end else if (r_state != LOAD && ce && w_err) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`else
    assign w_rd_data = r_mem[w_idx];
    assign sel_err   = 1'b0;
`endif

    // NOTE: the image is part of the reset state, so the memory array is cleared
    // in the reset branch like any other register; this keeps it out of block RAM.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_ptr   <= 4'd0;
            r_rd_q  <= 8'h00;
            r_oe_q  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_oe_q <= 1'b0;
                    if (prog_valid) begin
                        r_mem[r_ptr] <= prog_data;
                        r_ptr        <= r_ptr + 4'd1;
                        if (r_ptr == 4'd15) begin
                            r_done  <= 1'b1;
                            r_state <= RUN;
                        end else if (!prog_mode) begin
                            r_state <= IDLE;
                        end
                    end else if (!prog_mode) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    // A load request takes priority over a read in the same cycle.
                    if (prog_mode) begin
                        r_state <= LOAD;
                        r_ptr   <= 4'd0;
                        r_oe_q  <= 1'b0;
                    end else if (ce) begin
                        r_rd_q <= w_rd_data;
                        r_oe_q <= 1'b1;
                    end else begin
                        r_oe_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign wout       = r_oe_q ? r_rd_q : 8'hzz;
    assign prog_ready = (r_state == LOAD);
    assign prog_done  = r_done;

endmodule

// File: tb/tb_prom_rd.sv
// Directed bench for prom_rd: load, gapped load, abort, bus release, reset and one-hot handling.
// The W bus is a pulled-up net, so a released bus reads back as 8'hFF.
module tb_prom_rd;

    localparam logic [7:0] BUS_REL = 8'hFF;

    logic        clk;
    logic        clr_n;
    logic [15:0] sel;
    logic        ce;
    tri1  [7:0]  wout_bus;
    logic        prog_mode;
    logic        prog_valid;
    logic [7:0]  prog_data;
    logic        prog_ready;
    logic        prog_done;
    logic        sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    prom_rd dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .sel        (sel),
        .ce         (ce),
        .wout       (wout_bus),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_word(input string tag, input logic [15:0] s, input logic [7:0] exp);
        sel = s;
        ce  = 1'b1;
        tick();
        check(tag, 16'(wout_bus), 16'(exp));
    endtask

    int dones;

    initial begin
        clr_n      = 1'b0;
        sel        = 16'h0000;
        ce         = 1'b0;
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        prog_data  = 8'h00;
        #12;
        check("rst_wout", 16'(wout_bus), 16'(BUS_REL));
        check("rst_ready", 16'(prog_ready), 16'd0);
        check("rst_done", 16'(prog_done), 16'd0);
        check("rst_sel_err", 16'(sel_err), 16'd0);
        clr_n = 1'b1;
        read_word("idle_read_after_rst", 16'h0004, 8'h00);

        // Full load of 8'h10..8'h1F with prog_valid held.
        ce        = 1'b0;
        prog_mode = 1'b1;
        tick();
        check("load_ready_rise", 16'(prog_ready), 16'd1);
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1;
            prog_data  = 8'(8'h10 + i);
            tick();
            if (prog_done) dones++;
        end
        check("load_done_pulse", 16'(prog_done), 16'd1);
        check("load_ready_fall", 16'(prog_ready), 16'd0);
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        tick();
        if (prog_done) dones++;
        check("load_done_count", 16'(dones), 16'd1);
        read_word("run_read_0", 16'h0001, 8'h10);
        read_word("run_read_15", 16'h8000, 8'h1F);
        read_word("run_read_8", 16'h0100, 8'h18);
        read_word("run_read_10", 16'h0400, 8'h1A);
        ce = 1'b0;
        tick();
        check("ce_low_release", 16'(wout_bus), 16'(BUS_REL));

        // Select that is not one-hot.
`ifdef PROM_ONEHOT_CHECK_EN
        read_word("multi_sel_zero", 16'h0003, 8'h00);
        check("multi_sel_err", 16'(sel_err), 16'd1);
        read_word("err_sticky_read", 16'h0002, 8'h11);
        check("err_sticky", 16'(sel_err), 16'd1);
        read_word("zero_sel_read", 16'h0000, 8'h00);
`else
        read_word("multi_sel_lowest", 16'h0003, 8'h10);
        check("multi_sel_no_err", 16'(sel_err), 16'd0);
        read_word("plain_read_1", 16'h0002, 8'h11);
        read_word("zero_sel_read", 16'h0000, 8'h10);
        check("zero_sel_no_err", 16'(sel_err), 16'd0);
`endif

        // Load request together with a read: the transition wins and the bus releases.
        sel       = 16'h0002;
        ce        = 1'b1;
        prog_mode = 1'b1;
        tick();
        check("mode_beats_read", 16'(wout_bus), 16'(BUS_REL));
        check("reload_ready", 16'(prog_ready), 16'd1);
        check("reload_clears_err", 16'(sel_err), 16'd0);
        ce = 1'b0;

        // Gapped stream: valid on even cycles only, 32 cycles.
        dones = 0;
        for (int c = 0; c < 32; c++) begin
            prog_mode  = (c != 31);
            prog_valid = (c % 2 == 0);
            prog_data  = 8'(8'h40 + c / 2);
            tick();
            if (prog_done) dones++;
        end
        check("gap_done_count", 16'(dones), 16'd1);
        check("gap_ready_low", 16'(prog_ready), 16'd0);
        prog_valid = 1'b0;
        read_word("gap_read_0", 16'h0001, 8'h40);
        read_word("gap_read_5", 16'h0020, 8'h45);
        read_word("gap_read_15", 16'h8000, 8'h4F);
        ce = 1'b0;

        // Reset pulsed in the middle of a load.
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1;
        prog_data  = 8'h77;
        tick();
        tick();
        #2;
        clr_n = 1'b0;
        #1;
        check("midload_rst_wout", 16'(wout_bus), 16'(BUS_REL));
        check("midload_rst_ready", 16'(prog_ready), 16'd0);
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        read_word("post_rst_read_0", 16'h0001, 8'h00);
        read_word("post_rst_read_2", 16'h0004, 8'h00);
        read_word("post_rst_read_15", 16'h8000, 8'h00);
        ce = 1'b0;

        // Abort after five bytes, with ce held high during the load.
        prog_mode = 1'b1;
        tick();
        check("abort_ready", 16'(prog_ready), 16'd1);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1'b1;
            prog_data  = 8'(8'hA0 + i);
            sel        = 16'h0001;
            ce         = 1'b1;
            tick();
            if (prog_done) dones++;
            check("ce_in_load_release", 16'(wout_bus), 16'(BUS_REL));
        end
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        ce         = 1'b0;
        tick();
        if (prog_done) dones++;
        check("abort_no_done", 16'(dones), 16'd0);
        check("abort_ready_low", 16'(prog_ready), 16'd0);
        read_word("abort_read_4", 16'h0010, 8'hA4);
        read_word("abort_read_5", 16'h0020, 8'h00);
        read_word("abort_read_0", 16'h0001, 8'hA0);
        ce = 1'b0;
        tick();
        check("final_release", 16'(wout_bus), 16'(BUS_REL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
